axis_stall_detector: RTL

- Upstream feeder of the dataflow deadlock monitor.
- Watches the AXI-Stream valid/ready pair of each stream port on a dataflow instance.
- Asserts a per-channel axis_block_sigs bit once a port has been stalled for STALL_THRESH consecutive cycles.
- Also keeps sticky first-block capture and a saturating block-event counter for simulation debug readout.

---
 rtl/axis_dbg_pkg.sv | 25 ++
 rtl/axis_stall_chan.sv | 90 +++++++++
 rtl/axis_stall_detector.sv | 92 +++++++++
 3 files changed

// File: rtl/axis_dbg_pkg.sv
// Shared types and helpers for the AXI-Stream stall detector.
package axis_dbg_pkg;

  // Per-channel stall FSM state.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_BLOCKED  = 2'd2
  } chan_state_t;

  // Which end of the port the monitored instance sits on.
  localparam logic DIR_SINK   = 1'b0;
  localparam logic DIR_SOURCE = 1'b1;

  // Bits needed to index 'value' items (or hold values below 'value'); never less than 1.
  function automatic int clog2w(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_stall_chan.sv
// Single-channel stall watcher: counts consecutive stalled cycles and reports
// BLOCKED once the run reaches STALL_THRESH.
module axis_stall_chan
  import axis_dbg_pkg::*;
#(
  parameter int STALL_THRESH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic dir,
  input  logic valid,
  input  logic ready,
  output logic blocked,
  output logic enter_pulse
);

  localparam int CNT_W = clog2w(STALL_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_THRESH - 1);

  chan_state_t      state;
  chan_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stall;
  logic             enter;

  // A sink stalls when it is ready but starved; a source stalls when it
  // offers data that is not taken. A valid&ready transfer is never a stall.
  assign stall = (dir == DIR_SOURCE) ? (valid & ~ready) : (ready & ~valid);

  // Next-state and counter update; enable=0 forces IDLE regardless of state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    enter     = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if (stall) begin
            state_nxt = ST_COUNTING;
            cnt_nxt   = CNT_ONE;
          end
        end
        ST_COUNTING: begin
          if (!stall) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            // Counter stays frozen at its last value while BLOCKED.
            state_nxt = ST_BLOCKED;
            enter     = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_BLOCKED: begin
          if (!stall) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and stall counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign blocked     = (state == ST_BLOCKED);
  assign enter_pulse = enter;

endmodule

// File: rtl/axis_stall_detector.sv
// Monitors NUM_CHAN AXI-Stream ports for prolonged stalls and flags blocked
// channels to the deadlock monitor, with sticky first-block capture and a
// saturating block-event counter for debug readout.
module axis_stall_detector
  import axis_dbg_pkg::*;
#(
  parameter int NUM_CHAN     = 2,
  parameter int STALL_THRESH = 16,
  parameter int EVT_W        = 16,
  localparam int IDX_W       = clog2w(NUM_CHAN)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [NUM_CHAN-1:0] chan_dir,
  input  logic [NUM_CHAN-1:0] chan_valid,
  input  logic [NUM_CHAN-1:0] chan_ready,
  output logic [NUM_CHAN-1:0] axis_block_sigs,
  output logic                first_valid,
  output logic [IDX_W-1:0]    first_idx,
  output logic [EVT_W-1:0]    evt_count
);

  localparam int NENT_W = clog2w(NUM_CHAN + 1);

  logic [NUM_CHAN-1:0] blocked;
  logic [NUM_CHAN-1:0] enter;
  logic [NENT_W-1:0]   enter_cnt;
  logic [IDX_W-1:0]    enter_low;
  logic [EVT_W-1:0]    evt_next;

  // Event counter add that sticks at all-ones instead of wrapping.
  function automatic logic [EVT_W-1:0] sat_add(input logic [EVT_W-1:0] acc,
                                               input logic [NENT_W-1:0] inc);
    logic [EVT_W:0] sum;
    sum = {1'b0, acc} + (EVT_W + 1)'(inc);
    if (sum[EVT_W]) return '1;
    return sum[EVT_W-1:0];
  endfunction

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    axis_stall_chan #(
      .STALL_THRESH (STALL_THRESH)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .dir         (chan_dir[c]),
      .valid       (chan_valid[c]),
      .ready       (chan_ready[c]),
      .blocked     (blocked[c]),
      .enter_pulse (enter[c])
    );
  end

  assign axis_block_sigs = blocked;

  // Count simultaneous entries and pick the lowest-index entering channel.
  always_comb begin
    enter_cnt = '0;
    enter_low = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      enter_cnt = enter_cnt + NENT_W'(enter[i]);
    end
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (enter[i]) enter_low = IDX_W'(i);
    end
  end

  assign evt_next = sat_add(evt_count, enter_cnt);

  // Debug capture; clear takes priority over any entry in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_valid <= 1'b0;
      first_idx   <= '0;
      evt_count   <= '0;
    end else if (clear) begin
      first_valid <= 1'b0;
      first_idx   <= '0;
      evt_count   <= '0;
    end else if (|enter) begin
      evt_count <= evt_next;
      if (!first_valid) begin
        first_valid <= 1'b1;
        first_idx   <= enter_low;
      end
    end
  end

endmodule
